// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one req/gnt/rvalid data-bus transaction
// at a time, builds byte enables and replicated store data, and extends load data.
module mem_stage_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            mem_write_m_i,
  input  logic            mem_read_m_i,
  input  logic [2:0]      funct3_m_i,
  input  logic [XLEN-1:0] alu_result_m_i,
  input  logic [XLEN-1:0] write_data_m_i,
  input  logic            flush_m_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [XLEN-1:0] load_data_m_o,
  output logic            load_valid_m_o,
  output logic            stall_m_o,
  output logic            misaligned_m_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q, load_q;
  logic [3:0]      be_q;
  logic            we_q;
  logic [2:0]      f3_q;

  logic            access, mis, issue;
  logic [3:0]      be_live;
  logic [XLEN-1:0] wd_live;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = d;
    endcase
  endfunction

  // Reset gating keeps every output at zero while rst_n_i is held, even with live inputs.
  assign access = (mem_read_m_i | mem_write_m_i) & ~flush_m_i & rst_n_i;

  always_comb begin
    mis = 1'b0;
    if (funct3_m_i[1:0] == 2'b01 && alu_result_m_i[0])         mis = 1'b1;
    if (funct3_m_i[1:0] == 2'b10 && alu_result_m_i[1:0] != 0)  mis = 1'b1;
    if (funct3_m_i == 3'b011 || funct3_m_i == 3'b110 || funct3_m_i == 3'b111) mis = 1'b1;
    if (mem_write_m_i && funct3_m_i[2])                         mis = 1'b1;
  end

  assign issue          = (state_q == IDLE) & access & ~mis;
  assign misaligned_m_o = (state_q == IDLE) & access & mis;

  always_comb begin
    case (funct3_m_i[1:0])
      2'b00: begin
        be_live = 4'b0001 << alu_result_m_i[1:0];
        wd_live = {4{write_data_m_i[7:0]}};
      end
      2'b01: begin
        be_live = 4'b0011 << {alu_result_m_i[1], 1'b0};
        wd_live = {2{write_data_m_i[15:0]}};
      end
      default: begin
        be_live = 4'b1111;
        wd_live = write_data_m_i;
      end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    dmem_req_o     = 1'b0;
    dmem_we_o      = we_q;
    dmem_addr_o    = {addr_q[XLEN-1:2], 2'b00};
    dmem_be_o      = be_q;
    dmem_wdata_o   = wdata_q;
    stall_m_o      = 1'b0;
    load_valid_m_o = 1'b0;
    case (state_q)
      IDLE: if (issue) begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = mem_write_m_i;
        dmem_addr_o  = {alu_result_m_i[XLEN-1:2], 2'b00};
        dmem_be_o    = be_live;
        dmem_wdata_o = wd_live;
        stall_m_o    = 1'b1;
        state_d      = dmem_gnt_i ? RESP : REQ;
      end
      REQ: begin
        dmem_req_o = 1'b1;
        stall_m_o  = 1'b1;
        if (dmem_gnt_i) state_d = RESP;
      end
      RESP: begin
        stall_m_o = 1'b1;
        if (dmem_rvalid_i) state_d = DONE;
      end
      DONE: begin
        load_valid_m_o = ~we_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        addr_q  <= alu_result_m_i;
        be_q    <= be_live;
        wdata_q <= wd_live;
        we_q    <= mem_write_m_i;
        f3_q    <= funct3_m_i;
      end
      // Store acks carry no data, so only loads update the result register.
      if (state_q == RESP && dmem_rvalid_i && !we_q)
        load_q <= extract(f3_q, addr_q[1:0], dmem_rdata_i);
    end
  end

  assign load_data_m_o = load_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: hand-computed vectors for loads, stores,
// misalignment, flush, gnt back-pressure and reset during a transaction.
module tb_mem_stage_lsu;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        mem_write_m_i, mem_read_m_i, flush_m_i;
  logic [2:0]  funct3_m_i;
  logic [31:0] alu_result_m_i, write_data_m_i;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i, load_data_m_o;
  logic [3:0]  dmem_be_o;
  logic        load_valid_m_o, stall_m_o, misaligned_m_o;

  int total = 0;
  int bad   = 0;

  logic [3:0]  be;
  logic [31:0] wdat, ad;
  logic        we;

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .mem_write_m_i(mem_write_m_i), .mem_read_m_i(mem_read_m_i),
    .funct3_m_i(funct3_m_i), .alu_result_m_i(alu_result_m_i),
    .write_data_m_i(write_data_m_i), .flush_m_i(flush_m_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .load_data_m_o(load_data_m_o), .load_valid_m_o(load_valid_m_o),
    .stall_m_o(stall_m_o), .misaligned_m_o(misaligned_m_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read_m_i = 0; mem_write_m_i = 0; funct3_m_i = 0; alu_result_m_i = 0;
    write_data_m_i = 0; flush_m_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
  endtask

  // One full transaction: gnt arrives gdly cycles after issue, rvalid the cycle after gnt.
  task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                      input int gdly, output logic [3:0] obe, output logic [31:0] owd,
                      output logic owe, output logic [31:0] oad);
    @(negedge clk_i);
    mem_read_m_i = rd; mem_write_m_i = wr; funct3_m_i = f3;
    alu_result_m_i = a; write_data_m_i = wd; dmem_gnt_i = (gdly == 0);
    #1;
    obe = dmem_be_o; owd = dmem_wdata_o; owe = dmem_we_o; oad = dmem_addr_o;
    for (int i = 0; i <= gdly; i++) begin
      if (i > 0) begin
        @(negedge clk_i); dmem_gnt_i = (i == gdly); #1;
      end
      chk("req_held", {31'd0, dmem_req_o}, 32'd1);
      chk("stall_req", {31'd0, stall_m_o}, 32'd1);
      chk("be_stable", {28'd0, dmem_be_o}, {28'd0, obe});
      chk("addr_stable", dmem_addr_o, oad);
    end
    @(negedge clk_i);
    dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = rdata;
    #1;
    chk("resp_req", {31'd0, dmem_req_o}, 32'd0);
    chk("resp_stall", {31'd0, stall_m_o}, 32'd1);
    @(negedge clk_i);
    dmem_rvalid_i = 0;
    #1;
    chk("done_stall", {31'd0, stall_m_o}, 32'd0);
    chk("done_req", {31'd0, dmem_req_o}, 32'd0);
    chk("done_lvalid", {31'd0, load_valid_m_o}, {31'd0, rd & ~wr});
    @(negedge clk_i);
    mem_read_m_i = 0; mem_write_m_i = 0;
    #1;
    chk("post_lvalid", {31'd0, load_valid_m_o}, 32'd0);
    chk("post_req", {31'd0, dmem_req_o}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n_i = 0;
    #3;
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_m_o}, 32'd0);
    chk("rst_ldata", load_data_m_o, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    @(negedge clk_i); rst_n_i = 1;

    // LW, minimum latency
    xact(1, 0, 3'b010, 32'h0000_1004, 0, 32'hDEAD_BEEF, 0, be, wdat, we, ad);
    chk("lw_addr", ad, 32'h0000_1004);
    chk("lw_be", {28'd0, be}, 32'hF);
    chk("lw_we", {31'd0, we}, 32'd0);
    chk("lw_data", load_data_m_o, 32'hDEAD_BEEF);

    xact(1, 0, 3'b000, 32'h0000_1003, 0, 32'h80AA_BBCC, 0, be, wdat, we, ad);
    chk("lb_be", {28'd0, be}, 32'h8);
    chk("lb_addr", ad, 32'h0000_1000);
    chk("lb_data", load_data_m_o, 32'hFFFF_FF80);
    xact(1, 0, 3'b100, 32'h0000_1003, 0, 32'h80AA_BBCC, 0, be, wdat, we, ad);
    chk("lbu_data", load_data_m_o, 32'h0000_0080);
    xact(1, 0, 3'b001, 32'h0000_1002, 0, 32'h80AA_BBCC, 0, be, wdat, we, ad);
    chk("lh_be", {28'd0, be}, 32'hC);
    chk("lh_data", load_data_m_o, 32'hFFFF_80AA);
    xact(1, 0, 3'b101, 32'h0000_1000, 0, 32'h80AA_BBCC, 0, be, wdat, we, ad);
    chk("lhu_be", {28'd0, be}, 32'h3);
    chk("lhu_data", load_data_m_o, 32'h0000_BBCC);

    xact(0, 1, 3'b001, 32'h0000_2002, 32'hCAFE_1234, 0, 0, be, wdat, we, ad);
    chk("sh_we", {31'd0, we}, 32'd1);
    chk("sh_be", {28'd0, be}, 32'hC);
    chk("sh_wdata", wdat, 32'h1234_1234);
    chk("sh_addr", ad, 32'h0000_2000);
    xact(0, 1, 3'b000, 32'h0000_4001, 32'h0000_00A5, 0, 0, be, wdat, we, ad);
    chk("sb_be", {28'd0, be}, 32'h2);
    chk("sb_wdata", wdat, 32'hA5A5_A5A5);
    // read+write together is a store
    xact(1, 1, 3'b010, 32'h0000_5000, 32'h1111_2222, 0, 0, be, wdat, we, ad);
    chk("rw_we", {31'd0, we}, 32'd1);
    chk("rw_wdata", wdat, 32'h1111_2222);

    // gnt withheld 3 cycles: req held 4 cycles (checked inside xact)
    xact(1, 0, 3'b010, 32'h0000_3008, 0, 32'h1234_5678, 3, be, wdat, we, ad);
    chk("lwslow_addr", ad, 32'h0000_3008);
    chk("lwslow_data", load_data_m_o, 32'h1234_5678);

    // misaligned / illegal
    @(negedge clk_i);
    mem_read_m_i = 1; funct3_m_i = 3'b010; alu_result_m_i = 32'h0000_1002; #1;
    chk("mis_lw", {31'd0, misaligned_m_o}, 32'd1);
    chk("mis_lw_req", {31'd0, dmem_req_o}, 32'd0);
    chk("mis_lw_stall", {31'd0, stall_m_o}, 32'd0);
    @(negedge clk_i);
    funct3_m_i = 3'b001; alu_result_m_i = 32'h0000_1001; #1;
    chk("mis_lh", {31'd0, misaligned_m_o}, 32'd1);
    chk("mis_lh_req", {31'd0, dmem_req_o}, 32'd0);
    @(negedge clk_i);
    mem_read_m_i = 0; mem_write_m_i = 1; funct3_m_i = 3'b100; alu_result_m_i = 32'h0000_1000; #1;
    chk("mis_sbu", {31'd0, misaligned_m_o}, 32'd1);
    @(negedge clk_i);
    mem_write_m_i = 0; mem_read_m_i = 1; funct3_m_i = 3'b011; #1;
    chk("mis_f3_011", {31'd0, misaligned_m_o}, 32'd1);
    @(negedge clk_i);
    idle_inputs(); #1;
    chk("mis_clear", {31'd0, misaligned_m_o}, 32'd0);
    chk("mis_idle_req", {31'd0, dmem_req_o}, 32'd0);

    // flush in IDLE suppresses issue
    @(negedge clk_i);
    mem_read_m_i = 1; funct3_m_i = 3'b010; alu_result_m_i = 32'h0000_1000; flush_m_i = 1; #1;
    chk("flush_req", {31'd0, dmem_req_o}, 32'd0);
    chk("flush_stall", {31'd0, stall_m_o}, 32'd0);
    @(negedge clk_i); #1;
    chk("flush_req2", {31'd0, dmem_req_o}, 32'd0);
    @(negedge clk_i); idle_inputs();

    // reset while in RESP
    @(negedge clk_i);
    mem_read_m_i = 1; funct3_m_i = 3'b010; alu_result_m_i = 32'h0000_6004; dmem_gnt_i = 1; #1;
    chk("rr_issue", {31'd0, dmem_req_o}, 32'd1);
    @(negedge clk_i);
    dmem_gnt_i = 0; #1;
    chk("rr_resp_stall", {31'd0, stall_m_o}, 32'd1);
    rst_n_i = 0; #1;
    chk("rr_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rr_stall", {31'd0, stall_m_o}, 32'd0);
    chk("rr_addr", dmem_addr_o, 32'd0);
    chk("rr_be", {28'd0, dmem_be_o}, 32'd0);
    chk("rr_ldata", load_data_m_o, 32'd0);
    chk("rr_mis", {31'd0, misaligned_m_o}, 32'd0);
    @(negedge clk_i);
    idle_inputs(); rst_n_i = 1;
    @(negedge clk_i);
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h5555_AAAA; #1;
    chk("late_rv_stall", {31'd0, stall_m_o}, 32'd0);
    @(negedge clk_i);
    dmem_rvalid_i = 0; #1;
    chk("late_rv_lvalid", {31'd0, load_valid_m_o}, 32'd0);
    chk("late_rv_ldata", load_data_m_o, 32'd0);
    chk("late_rv_stall2", {31'd0, stall_m_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit. It consumes the M-stage control produced by the execute-to-memory control pipeline register (mem write, mem read, access size) together with the M-stage ALU address and store data. It drives a req/gnt/rvalid data-memory bus and generates byte enables and store-data lane replication. It also sign- or zero-extends load data and stalls the pipeline while a bus transaction is outstanding.

Parameters:
XLEN, 32, data and address width; only 32 is supported.

Ports:
clk_i  in  1  core clock
rst_n_i  in  1  asynchronous active-low reset
mem_write_m_i  in  1  store in M stage
mem_read_m_i  in  1  load in M stage
funct3_m_i  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; for stores 000/001/010 only
alu_result_m_i  in  32  byte address
write_data_m_i  in  32  store data (rs2)
flush_m_i  in  1  kill M-stage instruction
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  response/ack, exactly one per granted request
dmem_rdata_i  in  32  read data, valid with rvalid
load_data_m_o  out  32  extended load result
load_valid_m_o  out  1  load_data_m_o valid this cycle
stall_m_o  out  1  hold F/D/E/M pipeline registers
misaligned_m_o  out  1  misaligned or illegal access, no bus activity

Behaviour:
- Reset (async, any state): state=IDLE; latched addr/be/wdata/we/funct3 = 0; load data register = 0. All outputs read 0 while reset is held.
- access = (mem_read_m_i | mem_write_m_i) & ~flush_m_i. If both read and write are set, treat the access as a store.
- Misaligned when any of the following holds:
  - half access (funct3[1:0]=01) with addr[0]=1
  - word access with addr[1:0]≠00
  - funct3 ∈ {011,110,111}, or a store with funct3[2]=1
- A misaligned access sets misaligned_m_o=1 combinationally, issues no request, does not stall, and the FSM stays in IDLE.
- Byte enables: B = 0001<<addr[1:0]; H = 0011<<{addr[1],1'b0}; W = 1111. Loads use the same enables.
- Store data: SB = {4{wd[7:0]}}; SH = {2{wd[15:0]}}; SW = wd.
- FSM states:
  - IDLE: on an aligned access, dmem_req_o=1 combinationally using the live inputs, and all request fields are latched. stall_m_o=1. On gnt go to RESP, otherwise go to REQ.
  - REQ: dmem_req_o=1 with the latched fields held stable until gnt. stall=1. On gnt go to RESP.
  - RESP: req=0, stall=1. On rvalid, capture extract(rdata) into the load register and go to DONE. rvalid is also legal in the same cycle as the REQ→RESP gnt only if the bus is combinational; rvalid in REQ is ignored.
  - DONE: stall=0, req=0, load_valid_m_o=1 if the latched access was a load. Always go to IDLE next cycle; no re-issue, even though the same instruction is still visible on the inputs.
- Load extraction (byte at addr[1:0], half at addr[1]):
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - load_data_m_o is the registered value; it holds until the next capture.
- Minimum latency with gnt in the issue cycle and rvalid one cycle later: stall high for 2 cycles, result valid in cycle 3 (DONE).
- flush_m_i only suppresses issue in IDLE. Once granted or pending, the transaction always completes and stall is held until DONE; the pipeline discards the result.
- No pipelining of requests: at most one outstanding transaction.
- Reset mid-transaction returns to IDLE immediately. Any late rvalid after reset is ignored in IDLE.

Test Plan:
- LW addr 0x0000_1004, gnt in the issue cycle, rvalid+1 with rdata 0xDEAD_BEEF → dmem_addr 0x1004, be 1111, stall high for 2 cycles, then load_data_m_o=0xDEAD_BEEF and load_valid=1 for 1 cycle.
- LB addr 0x1003, rdata 0x80AA_BBCC → be 1000, load_data 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH addr 0x2002, wd 0xCAFE_1234 → we=1, be 1100, wdata 0x1234_1234, load_valid stays 0.
- LW with gnt withheld 3 cycles → req held 4 cycles, addr/be stable, stall remains until DONE.
- LW addr 0x1002, then LH addr 0x1001 → misaligned_m_o=1, dmem_req_o=0, stall_m_o=0.
- rst_n_i low while in RESP → all outputs 0 and state IDLE. A subsequent rvalid is ignored. flush_m_i with a load in IDLE → no req, no stall.
